// File: rtl/avalon_st_demultiplexer.sv
// Packet-level 1-to-2 Avalon-ST demultiplexer: each sop..eop packet is steered
// by its sop-beat channel into one of two 2-entry output FIFOs.
module avalon_st_demultiplexer #(
  parameter int unsigned channel_width = 8,
  parameter int unsigned data_width    = 32,
  parameter int unsigned empty_width   = 2,
  parameter int unsigned split_channel = 128
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic [channel_width-1:0] avsi_channel,
  input  logic [data_width-1:0]    avsi_data,
  input  logic                     avsi_valid,
  input  logic                     avsi_sop,
  input  logic                     avsi_eop,
  input  logic [empty_width-1:0]   avsi_empty,
  output logic                     avsi_ready,
  output logic [channel_width-1:0] avso_one_channel,
  output logic [data_width-1:0]    avso_one_data,
  output logic                     avso_one_sop,
  output logic                     avso_one_eop,
  output logic [empty_width-1:0]   avso_one_empty,
  output logic                     avso_one_valid,
  input  logic                     avso_one_ready,
  output logic [channel_width-1:0] avso_two_channel,
  output logic [data_width-1:0]    avso_two_data,
  output logic                     avso_two_sop,
  output logic                     avso_two_eop,
  output logic [empty_width-1:0]   avso_two_empty,
  output logic                     avso_two_valid,
  input  logic                     avso_two_ready,
  output logic [15:0]              drop_count,
  output logic                     proto_err
);

  localparam int unsigned EOP_BIT = empty_width;
  localparam int unsigned SOP_BIT = empty_width + 1;
  localparam int unsigned DATA_LO = empty_width + 2;
  localparam int unsigned CH_LO   = DATA_LO + data_width;
  localparam int unsigned PW      = CH_LO + channel_width;

  typedef enum logic [1:0] {IDLE, PKT_ONE, PKT_TWO} state_t;

  state_t          state, state_next;
  logic [1:0]      count  [2];
  logic            rd_ptr [2];
  logic            wr_ptr [2];
  logic [PW-1:0]   mem    [2][2];
  logic [PW-1:0]   beat_c, head_one_c, head_two_c;
  logic            to_two_c, fire_c, drop_c, err_c;
  logic [1:0]      push_c, pop_c;

  assign beat_c   = {avsi_channel, avsi_data, avsi_sop, avsi_eop, avsi_empty};
  assign to_two_c = 32'(avsi_channel) >= split_channel;
  assign fire_c   = avsi_valid && avsi_ready;
  assign pop_c    = {avso_two_valid && avso_two_ready, avso_one_valid && avso_one_ready};

  // Ready sees registered counts only; a sop beat must find room on both sides.
  always_comb begin
    avsi_ready = 1'b0;
    if (reset_n) begin
      if (state == IDLE || avsi_sop)
        avsi_ready = (count[0] < 2'd2) && (count[1] < 2'd2);
      else if (state == PKT_ONE)
        avsi_ready = count[0] < 2'd2;
      else
        avsi_ready = count[1] < 2'd2;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (fire_c && avsi_sop && !avsi_eop)
          state_next = to_two_c ? PKT_TWO : PKT_ONE;
      end
      PKT_ONE, PKT_TWO: begin
        if (fire_c) begin
          if (avsi_sop)
            state_next = avsi_eop ? IDLE : (to_two_c ? PKT_TWO : PKT_ONE);
          else if (avsi_eop)
            state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // A sop beat always restarts routing, even when it truncates an open packet.
  always_comb begin
    push_c = 2'b00;
    drop_c = 1'b0;
    err_c  = 1'b0;
    if (fire_c) begin
      if (avsi_sop) begin
        push_c = to_two_c ? 2'b10 : 2'b01;
        err_c  = state != IDLE;
      end else begin
        case (state)
          IDLE: begin
            drop_c = 1'b1;
            err_c  = 1'b1;
          end
          PKT_ONE: push_c = 2'b01;
          PKT_TWO: push_c = 2'b10;
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int k = 0; k < 2; k++) begin
        count[k]  <= 2'd0;
        rd_ptr[k] <= 1'b0;
        wr_ptr[k] <= 1'b0;
        for (int e = 0; e < 2; e++) mem[k][e] <= '0;
      end
    end else begin
      for (int k = 0; k < 2; k++) begin
        if (push_c[k]) begin
          mem[k][wr_ptr[k]] <= beat_c;
          wr_ptr[k]         <= ~wr_ptr[k];
        end
        if (pop_c[k]) rd_ptr[k] <= ~rd_ptr[k];
        if (push_c[k] && !pop_c[k])      count[k] <= count[k] + 2'd1;
        else if (!push_c[k] && pop_c[k]) count[k] <= count[k] - 2'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      drop_count <= 16'd0;
      proto_err  <= 1'b0;
    end else begin
      proto_err <= err_c;
      if (drop_c && drop_count != 16'hFFFF) drop_count <= drop_count + 16'd1;
    end
  end

  assign head_one_c = mem[0][rd_ptr[0]];
  assign head_two_c = mem[1][rd_ptr[1]];

  assign avso_one_valid   = count[0] != 2'd0;
  assign avso_one_channel = head_one_c[CH_LO +: channel_width];
  assign avso_one_data    = head_one_c[DATA_LO +: data_width];
  assign avso_one_sop     = head_one_c[SOP_BIT];
  assign avso_one_eop     = head_one_c[EOP_BIT];
  assign avso_one_empty   = head_one_c[empty_width-1:0];

  assign avso_two_valid   = count[1] != 2'd0;
  assign avso_two_channel = head_two_c[CH_LO +: channel_width];
  assign avso_two_data    = head_two_c[DATA_LO +: data_width];
  assign avso_two_sop     = head_two_c[SOP_BIT];
  assign avso_two_eop     = head_two_c[EOP_BIT];
  assign avso_two_empty   = head_two_c[empty_width-1:0];

endmodule

// File: tb/tb_avalon_st_demultiplexer.sv
// Scoreboard bench for avalon_st_demultiplexer: a routing model fills per-output
// queues on acceptance; output monitors pop and compare every transferred beat.
module tb_avalon_st_demultiplexer;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [7:0]  avsi_channel;
  logic [31:0] avsi_data;
  logic        avsi_valid, avsi_sop, avsi_eop, avsi_ready;
  logic [1:0]  avsi_empty;
  logic [7:0]  one_channel, two_channel;
  logic [31:0] one_data, two_data;
  logic        one_sop, one_eop, one_valid, two_sop, two_eop, two_valid;
  logic [1:0]  one_empty, two_empty;
  logic        rdy_one, rdy_two;
  logic [15:0] drop_count;
  logic        proto_err;

  always #5 clk = ~clk;

  avalon_st_demultiplexer dut (
    .clk(clk), .reset_n(reset_n),
    .avsi_channel(avsi_channel), .avsi_data(avsi_data), .avsi_valid(avsi_valid),
    .avsi_sop(avsi_sop), .avsi_eop(avsi_eop), .avsi_empty(avsi_empty), .avsi_ready(avsi_ready),
    .avso_one_channel(one_channel), .avso_one_data(one_data), .avso_one_sop(one_sop),
    .avso_one_eop(one_eop), .avso_one_empty(one_empty), .avso_one_valid(one_valid),
    .avso_one_ready(rdy_one),
    .avso_two_channel(two_channel), .avso_two_data(two_data), .avso_two_sop(two_sop),
    .avso_two_eop(two_eop), .avso_two_empty(two_empty), .avso_two_valid(two_valid),
    .avso_two_ready(rdy_two),
    .drop_count(drop_count), .proto_err(proto_err)
  );

  int          checks = 0, errors = 0;
  int          n_one = 0, n_two = 0, err_seen = 0, exp_err = 0;
  logic [15:0] exp_drop = 16'd0;
  logic [43:0] q_one[$], q_two[$];
  bit          in_pkt = 1'b0, pkt_two = 1'b0, soak = 1'b0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Output monitors: a beat moves at the posedge following a negedge with valid && ready.
  always @(negedge clk) begin
    if (reset_n) begin
      if (proto_err) err_seen++;
      if (one_valid && rdy_one) begin
        n_one++;
        if (q_one.size() == 0) check("one_extra_beat", 1, 0);
        else check("one_beat", {one_channel, one_data, one_sop, one_eop, one_empty}, q_one.pop_front());
      end
      if (two_valid && rdy_two) begin
        n_two++;
        if (q_two.size() == 0) check("two_extra_beat", 1, 0);
        else check("two_beat", {two_channel, two_data, two_sop, two_eop, two_empty}, q_two.pop_front());
      end
    end
  end

  always begin
    @(posedge clk);
    #1;
    if (soak) begin
      rdy_one = ($urandom_range(0, 3) != 0);
      rdy_two = ($urandom_range(0, 3) != 0);
    end
  end

  // Reference routing on acceptance; entered and left at posedge+1.
  task automatic send(input logic [7:0] ch, input logic [31:0] d, input logic sop,
                      input logic eop, input logic [1:0] emp);
    bit acc = 1'b0;
    bit tgt;
    logic [43:0] b;
    avsi_channel = ch; avsi_data = d; avsi_sop = sop; avsi_eop = eop;
    avsi_empty = emp; avsi_valid = 1'b1;
    b = {ch, d, sop, eop, emp};
    for (int n = 0; n < 400 && !acc; n++) begin
      @(negedge clk);
      if (avsi_ready) begin
        acc = 1'b1;
        if (sop) begin
          if (in_pkt) exp_err++;
          tgt = (ch >= 8'd128);
          if (tgt) q_two.push_back(b); else q_one.push_back(b);
          pkt_two = tgt;
          in_pkt  = !eop;
        end else if (in_pkt) begin
          if (pkt_two) q_two.push_back(b); else q_one.push_back(b);
          if (eop) in_pkt = 1'b0;
        end else begin
          exp_err++;
          if (exp_drop != 16'hFFFF) exp_drop++;
        end
      end
      @(posedge clk);
      #1;
    end
    if (!acc) check("accept_timeout", 0, 1);
    avsi_valid = 1'b0;
  endtask

  task automatic drain();
    for (int n = 0; n < 3000 && (q_one.size() != 0 || q_two.size() != 0); n++) begin
      @(posedge clk);
      #1;
    end
    check("drain_one", q_one.size(), 0);
    check("drain_two", q_two.size(), 0);
    repeat (2) @(posedge clk);
    #1;
  endtask

  initial begin
    int base_one, base_two;
    reset_n = 1'b0; avsi_valid = 1'b0; avsi_sop = 1'b0; avsi_eop = 1'b0;
    avsi_channel = '0; avsi_data = '0; avsi_empty = '0;
    rdy_one = 1'b1; rdy_two = 1'b1;
    #2;
    check("rst_ready", avsi_ready, 0);
    check("rst_valids", {one_valid, two_valid}, 0);
    check("rst_payload", {one_channel, one_data, two_channel, two_data}, 0);
    check("rst_stats", {drop_count, proto_err}, 0);
    repeat (2) @(posedge clk);
    @(negedge clk) reset_n = 1'b1;
    @(posedge clk);
    #1;
    check("post_rst_ready", avsi_ready, 1);

    // Single-beat routing and one-cycle latency
    send(8'd5, 32'h1111_0005, 1'b1, 1'b1, 2'd1);
    check("lat_one_valid", {one_valid, two_valid}, 2'b10);
    check("lat_one_data", one_data, 32'h1111_0005);
    send(8'd200, 32'h2222_00C8, 1'b1, 1'b1, 2'd2);
    check("lat_two_valid", two_valid, 1);
    check("lat_two_flags", {two_sop, two_eop, two_empty}, 4'b1110);
    drain();

    // Backpressure on output two
    base_one = n_one;
    rdy_two = 1'b0;
    send(8'd130, 32'hB000_0001, 1'b1, 1'b0, 2'd0);
    send(8'd130, 32'hB000_0002, 1'b0, 1'b0, 2'd0);
    avsi_data = 32'hB000_0003; avsi_sop = 1'b0; avsi_eop = 1'b0; avsi_valid = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check("bp_ready_low", avsi_ready, 0);
      check("bp_hold", {two_valid, two_data}, {1'b1, 32'hB000_0001});
    end
    @(posedge clk);
    #1;
    rdy_two = 1'b1;
    send(8'd130, 32'hB000_0003, 1'b0, 1'b0, 2'd0);
    send(8'd130, 32'hB000_0004, 1'b0, 1'b1, 2'd3);
    drain();
    check("bp_one_idle", n_one - base_one, 0);

    // Channel split boundary
    base_one = n_one; base_two = n_two;
    send(8'd127, 32'h0000_007F, 1'b1, 1'b1, 2'd0);
    send(8'd128, 32'h0000_0080, 1'b1, 1'b1, 2'd0);
    drain();
    check("bnd_one", n_one - base_one, 1);
    check("bnd_two", n_two - base_two, 1);

    // Orphan beats
    repeat (3) send(8'd9, 32'hDEAD_0000, 1'b0, 1'b0, 2'd0);
    repeat (2) @(posedge clk);
    #1;
    check("orphan_drop", drop_count, 16'd3);
    check("orphan_err", err_seen, exp_err);
    avsi_sop = 1'b0; avsi_valid = 1'b1;
    repeat (70000) @(posedge clk);
    #1;
    avsi_valid = 1'b0;
    exp_drop = 16'hFFFF;
    exp_err += 70000;
    repeat (2) @(posedge clk);
    #1;
    check("drop_sat", drop_count, exp_drop);
    check("drop_sat_err", err_seen, exp_err);
    drain();

    // Missing eop
    send(8'd10, 32'hA000_0001, 1'b1, 1'b0, 2'd0);
    send(8'd10, 32'hA000_0002, 1'b0, 1'b0, 2'd0);
    send(8'd250, 32'hC000_0001, 1'b1, 1'b0, 2'd0);
    check("trunc_err_hi", proto_err, 1);
    send(8'd250, 32'hC000_0002, 1'b0, 1'b0, 2'd0);
    check("trunc_err_lo", proto_err, 0);
    send(8'd250, 32'hC000_0003, 1'b0, 1'b1, 2'd3);
    drain();
    check("trunc_err_count", err_seen, exp_err);

    // Reset mid-packet with FIFOs filled as far as ready allows
    rdy_one = 1'b0; rdy_two = 1'b0;
    send(8'd20, 32'h5000_0001, 1'b1, 1'b1, 2'd0);
    send(8'd200, 32'h6000_0001, 1'b1, 1'b0, 2'd0);
    send(8'd200, 32'h6000_0002, 1'b0, 1'b0, 2'd0);
    check("pre_rst_full", {one_valid, two_valid, avsi_ready}, 3'b110);
    #3 reset_n = 1'b0;
    #1;
    check("mid_rst_valids", {one_valid, two_valid, avsi_ready}, 0);
    check("mid_rst_payload", {two_channel, two_data, drop_count}, 0);
    q_one.delete(); q_two.delete(); in_pkt = 1'b0; exp_drop = 16'd0;
    rdy_one = 1'b1; rdy_two = 1'b1;
    @(negedge clk) reset_n = 1'b1;
    @(posedge clk);
    #1;
    check("rel_ready", avsi_ready, 1);
    base_two = n_two;
    send(8'd128, 32'h7000_0001, 1'b1, 1'b1, 2'd1);
    send(8'd3, 32'h7000_0002, 1'b1, 1'b1, 2'd2);
    drain();
    check("rel_routed", n_two - base_two, 1);

    // Random soak
    soak = 1'b1;
    for (int p = 0; p < 1000; p++) begin
      int len;
      logic [7:0] ch;
      len = $urandom_range(1, 4);
      ch  = 8'($urandom_range(0, 255));
      for (int b = 0; b < len; b++)
        send(ch, $urandom, b == 0, b == len - 1, 2'($urandom_range(0, 3)));
    end
    soak = 1'b0;
    @(posedge clk);
    #2;
    rdy_one = 1'b1; rdy_two = 1'b1;
    drain();
    check("soak_err", err_seen, exp_err);
    check("soak_drop", drop_count, exp_drop);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
